pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter IMEM_LAT, default 1, meaning IMEM read latency in cycles; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 24, meaning width of the retired-instruction counter.
REQ-003 clk  input  1  single system clock; all state changes on posedge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  leave IDLE or HALT and begin fetching.
REQ-006 halt_req  input  1  level; stop after the current instruction retires.
REQ-007 imem_ready  input  1  IMEM read data valid.
REQ-008 exec_done  input  1  datapath finished the current instruction.
REQ-009 jump  input  1  qualifies exec_done; the next PC is taken from the C bus.
REQ-010 stall  input  1  freezes EXEC.
REQ-011 imem_rd  output  1  IMEM read strobe.
REQ-012 ir_load  output  1  instruction register load strobe.
REQ-013 pc_inc  output  1  drives the PC increment input.
REQ-014 pc_write  output  1  drives the PC write input (load from C bus).
REQ-015 busy  output  1  high in FETCH, WAIT, LOAD and EXEC.
REQ-016 halted  output  1  high in HALT.
REQ-017 state  output  3  FSM state code, for debug.
REQ-018 instr_cnt  output  CNT_W  count of retired instructions (exists only with the macro in REQ-036).

Function
REQ-019 FSM encoding SHALL be IDLE=0, FETCH=1, WAIT=2, LOAD=3, EXEC=4, HALT=5; codes 6 and 7 go to IDLE next cycle.
REQ-020 IDLE: all strobes 0; start=1 -> FETCH next cycle; halt_req ignored.
REQ-021 FETCH: imem_rd=1 for exactly this one cycle; wait counter loads IMEM_LAT-1; -> WAIT.
REQ-022 WAIT: counter decrements to 0 and holds; exit to LOAD only when counter==0 and imem_ready=1; otherwise stay.
REQ-023 With IMEM_LAT=1, the earliest LOAD is 2 cycles after FETCH (FETCH, WAIT, LOAD).
REQ-024 LOAD: ir_load=1 for exactly one cycle; -> EXEC.
REQ-025 EXEC: stall=1 holds state and suppresses all strobes, including when exec_done=1.
REQ-026 EXEC with exec_done=1 and stall=0: jump=1 gives pc_write=1 and pc_inc=0; jump=0 gives pc_inc=1 and pc_write=0; combinational, same cycle.
REQ-027 pc_inc and pc_write SHALL never be high in the same cycle; both are high only in a retiring EXEC cycle.
REQ-028 After retirement: halt_req=1 in that cycle -> HALT; otherwise -> FETCH.
REQ-029 HALT: strobes 0, halted=1; start=1 -> FETCH with no PC change (resume at the next PC).
REQ-030 start while busy SHALL be ignored.
REQ-031 busy and halted SHALL be registered-state decodes, never both high.
REQ-032 instr_cnt SHALL increment by 1 on each retiring cycle, wrapping from all-ones to 0 without a flag.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, wait counter=0 and instr_cnt=0, with all outputs 0.
REQ-034 Reset mid-operation (any state, including during an imem_rd or pc_inc cycle) SHALL drop the strobe in the same cycle, and no retirement is counted.
REQ-035 After rst_n rises, the first FETCH SHALL require a start pulse.

Configuration
REQ-036 Macro PC_SEQ_INSTR_CNT_EN defined: the instr_cnt port and counter SHALL exist per REQ-018, REQ-032 and REQ-033.
REQ-037 Macro PC_SEQ_INSTR_CNT_EN undefined: no instr_cnt port and no counter logic SHALL exist; all other behaviour is identical.

Verification
REQ-038 Reset; start pulse at cycle 0; imem_ready=1; exec_done at the 2nd EXEC cycle, jump=0 -> states 1,2,3,4,4 then 1; pc_inc=1 for exactly one cycle; instr_cnt=1.
REQ-039 IMEM_LAT=4 with imem_ready low until 6 cycles after FETCH -> WAIT lasts 6 cycles; ir_load occurs the cycle after imem_ready rises.
REQ-040 EXEC with exec_done=1, jump=1, stall=1 for 3 cycles, then stall=0 -> no strobes for 3 cycles, then pc_write=1 and pc_inc=0 for one cycle.
REQ-041 halt_req=1 at retirement -> HALT, halted=1, busy=0; start -> FETCH; instr_cnt keeps counting from its prior value.
REQ-042 rst_n low during WAIT and again during a pc_inc cycle -> state=0, strobe low immediately, instr_cnt=0; no start pulse afterwards -> stays in IDLE.
REQ-043 CNT_W=4, 17 retirements -> instr_cnt wraps to 1; build without PC_SEQ_INSTR_CNT_EN -> elaborates with no instr_cnt port.

Source files
------------

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// =============================================================================
// pc_sequencer_if : control/handshake bundle between the PC sequencer and the
//                   datapath / IMEM side. instr_cnt exists with PC_SEQ_INSTR_CNT_EN.
// Rev 1.0
// =============================================================================
interface pc_sequencer_if #(
  parameter int CNT_W = 24
);
  logic       start;
  logic       halt_req;
  logic       imem_ready;
  logic       exec_done;
  logic       jump;
  logic       stall;
  logic       imem_rd;
  logic       ir_load;
  logic       pc_inc;
  logic       pc_write;
  logic       busy;
  logic       halted;
  logic [2:0] state;
`ifdef PC_SEQ_INSTR_CNT_EN
  logic [CNT_W-1:0] instr_cnt;
`endif

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("pc_sequencer_if: CNT_W must be at least 1");
  end

  modport master (
    input  start, halt_req, imem_ready, exec_done, jump, stall,
`ifdef PC_SEQ_INSTR_CNT_EN
    output instr_cnt,
`endif
    output imem_rd, ir_load, pc_inc, pc_write, busy, halted, state
  );

  modport slave (
    output start, halt_req, imem_ready, exec_done, jump, stall,
`ifdef PC_SEQ_INSTR_CNT_EN
    input  instr_cnt,
`endif
    input  imem_rd, ir_load, pc_inc, pc_write, busy, halted, state
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// =============================================================================
// pc_sequencer : fetch/wait/load/exec sequencer driving PC and IR strobes.
//                Retired-instruction counter exists with PC_SEQ_INSTR_CNT_EN.
// Rev 1.0
// =============================================================================
module pc_sequencer #(
  parameter int IMEM_LAT = 1,
  parameter int CNT_W    = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_EXEC  = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  localparam logic [3:0] c_wait_init = 4'(IMEM_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;

  if (IMEM_LAT < 1 || IMEM_LAT > 15 || CNT_W < 1) begin : g_param_check
    $error("pc_sequencer: IMEM_LAT must be 1..15 and CNT_W at least 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    bus.imem_rd  = 1'b0;
    bus.ir_load  = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_write = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.imem_rd = 1'b1;
        wait_d      = c_wait_init;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // Latency must fully elapse before imem_ready is trusted.
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else if (bus.imem_ready) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        bus.ir_load = 1'b1;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        if (bus.exec_done && !bus.stall) begin
          bus.pc_write = bus.jump;
          bus.pc_inc   = !bus.jump;
          state_d      = bus.halt_req ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        if (bus.start) state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy   = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                      (state_q == S_LOAD)  || (state_q == S_EXEC);
  assign bus.halted = (state_q == S_HALT);
  assign bus.state  = state_q;

`ifdef PC_SEQ_INSTR_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
    end else if (bus.pc_inc || bus.pc_write) begin
      instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign bus.instr_cnt = instr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// tb_pc_sequencer: two configurations (IMEM_LAT=1/CNT_W=4, IMEM_LAT=4/CNT_W=24) share one
// stimulus stream; each is compared every cycle against a behavioural model.
module tb_pc_sequencer;

  localparam int c_lat0  = 1;
  localparam int c_lat1  = 4;
  localparam int c_cw0   = 4;
  localparam int c_cw1   = 24;
  localparam int unsigned c_mask0 = 32'h0000_000F;
  localparam int unsigned c_mask1 = 32'h00FF_FFFF;

  localparam int c_m_idle  = 0;
  localparam int c_m_halt  = 1;
  localparam int c_m_fetch = 2;
  localparam int c_m_load  = 3;
  localparam int c_m_exec  = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       rd;
    logic       ld;
    logic       inc;
    logic       wr;
    logic       busy;
    logic       hlt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, halt_req, imem_ready, exec_done, jump, stall;

  always #5 clk = ~clk;

  pc_sequencer_if #(.CNT_W(c_cw0)) b0 ();
  pc_sequencer_if #(.CNT_W(c_cw1)) b1 ();

  assign b0.start      = start;
  assign b0.halt_req   = halt_req;
  assign b0.imem_ready = imem_ready;
  assign b0.exec_done  = exec_done;
  assign b0.jump       = jump;
  assign b0.stall      = stall;
  assign b1.start      = start;
  assign b1.halt_req   = halt_req;
  assign b1.imem_ready = imem_ready;
  assign b1.exec_done  = exec_done;
  assign b1.jump       = jump;
  assign b1.stall      = stall;

  pc_sequencer #(.IMEM_LAT(c_lat0), .CNT_W(c_cw0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  pc_sequencer #(.IMEM_LAT(c_lat1), .CNT_W(c_cw1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          ret0_total = 0;
  int          m_mode [2];
  int          m_age  [2];
  int unsigned m_cnt  [2];
  obs_t        tr0 [$];
  obs_t        tr1 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Behavioural model: the wait phase is tracked as "age since the fetch cycle".
  task automatic monitor();
    obs_t        act [2];
    logic [31:0] act_cnt [2];
    obs_t        exp_o;
    int          lat, nmode, nage;
    int unsigned mask, ncnt;
    act[0] = {b0.state, b0.imem_rd, b0.ir_load, b0.pc_inc, b0.pc_write, b0.busy, b0.halted};
    act[1] = {b1.state, b1.imem_rd, b1.ir_load, b1.pc_inc, b1.pc_write, b1.busy, b1.halted};
    act_cnt[0] = 32'd0;
    act_cnt[1] = 32'd0;
`ifdef PC_SEQ_INSTR_CNT_EN
    act_cnt[0] = 32'(b0.instr_cnt);
    act_cnt[1] = 32'(b1.instr_cnt);
`endif
    tr0.push_back(act[0]);
    tr1.push_back(act[1]);
    if (rst_n && (act[0].inc || act[0].wr)) ret0_total++;
    for (int k = 0; k < 2; k++) begin
      lat   = (k == 0) ? c_lat0 : c_lat1;
      mask  = (k == 0) ? c_mask0 : c_mask1;
      exp_o = '0;
      nmode = m_mode[k];
      nage  = m_age[k];
      if (!rst_n) begin
        nmode    = c_m_idle;
        nage     = 0;
        m_cnt[k] = 0;
      end else begin
        case (m_mode[k])
          c_m_idle: begin
            if (start) begin nmode = c_m_fetch; nage = 0; end
          end
          c_m_halt: begin
            exp_o.st  = 3'd5;
            exp_o.hlt = 1'b1;
            if (start) begin nmode = c_m_fetch; nage = 0; end
          end
          c_m_fetch: begin
            exp_o.busy = 1'b1;
            if (m_age[k] == 0) begin
              exp_o.st = 3'd1;
              exp_o.rd = 1'b1;
              nage     = 1;
            end else begin
              exp_o.st = 3'd2;
              if (m_age[k] >= lat && imem_ready) nmode = c_m_load;
              else if (m_age[k] < 100) nage = m_age[k] + 1;
            end
          end
          c_m_load: begin
            exp_o.st   = 3'd3;
            exp_o.ld   = 1'b1;
            exp_o.busy = 1'b1;
            nmode      = c_m_exec;
          end
          c_m_exec: begin
            exp_o.st   = 3'd4;
            exp_o.busy = 1'b1;
            if (exec_done && !stall) begin
              if (jump) exp_o.wr = 1'b1;
              else      exp_o.inc = 1'b1;
              nmode = halt_req ? c_m_halt : c_m_fetch;
              nage  = 0;
            end
          end
          default: nmode = c_m_idle;
        endcase
      end
      ncnt = (rst_n && (exp_o.inc || exp_o.wr)) ? ((m_cnt[k] + 1) & mask) : m_cnt[k];
      n_cmp++;
      if (act[k] !== exp_o) begin
        n_bad++;
        $display("FAIL dut%0d outputs cycle %0d: got st=%0d rd,ld,inc,wr,busy,halted=%b required st=%0d rd,ld,inc,wr,busy,halted=%b",
                 k, cyc, act[k].st, act[k][5:0], exp_o.st, exp_o[5:0]);
      end
`ifdef PC_SEQ_INSTR_CNT_EN
      n_cmp++;
      if (act_cnt[k] !== m_cnt[k]) begin
        n_bad++;
        $display("FAIL dut%0d instr_cnt cycle %0d: got %0d required %0d", k, cyc, act_cnt[k], m_cnt[k]);
      end
`endif
      m_mode[k] = nmode;
      m_age[k]  = nage;
      m_cnt[k]  = ncnt;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; halt_req = 0; imem_ready = 0; exec_done = 0; jump = 0; stall = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic wait_state0(input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (b0.state !== s && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (b0.state !== s) begin
      n_bad++;
      $display("FAIL wait_state0 timeout: state %0d, required %0d", b0.state, s);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_st [7];
    int cnt2, base, n;
    exp_st = '{0, 1, 2, 3, 4, 4, 1};
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = c_m_idle; m_age[k] = 0; m_cnt[k] = 0;
    end
    start = 0; halt_req = 0; imem_ready = 0; exec_done = 0; jump = 0; stall = 0;
    rst_n = 0;
    tick();
    tick();
    chk("rst_state0", 32'(b0.state), 32'd0);
    chk("rst_busy0", 32'(b0.busy), 32'd0);
    chk("rst_strobes0", 32'({b0.imem_rd, b0.ir_load, b0.pc_inc, b0.pc_write, b0.halted}), 32'd0);
`ifdef PC_SEQ_INSTR_CNT_EN
    chk("rst_cnt0", 32'(b0.instr_cnt), 32'd0);
`endif
    rst_n = 1;
    repeat (4) tick();
    chk("no_start_idle0", 32'(b0.state), 32'd0);
    chk("no_start_idle1", 32'(b1.state), 32'd0);

    // Basic fetch/retire sequence, IMEM_LAT=1.
    do_reset();
    tick();
    tr0.delete(); tr1.delete();
    imem_ready = 1; start = 1;
    tick(); start = 0;
    repeat (4) tick();
    exec_done = 1;
    tick(); exec_done = 0;
    repeat (4) tick();
    for (int i = 0; i < 7; i++) chk($sformatf("seq_state[%0d]", i), 32'(tr0[i].st), 32'(exp_st[i]));
    cnt2 = 0;
    foreach (tr0[i]) if (tr0[i].inc) cnt2++;
    chk("seq_pc_inc_count", 32'(cnt2), 32'd1);
`ifdef PC_SEQ_INSTR_CNT_EN
    chk("seq_instr_cnt", 32'(b0.instr_cnt), 32'd1);
`endif

    // Long IMEM latency with late imem_ready.
    do_reset();
    tick();
    tr0.delete(); tr1.delete();
    start = 1; imem_ready = 0;
    tick(); start = 0;
    repeat (6) tick();
    imem_ready = 1;
    repeat (3) tick();
    chk("lat4_fetch_state", 32'(tr1[1].st), 32'd1);
    cnt2 = 0;
    foreach (tr1[i]) if (tr1[i].st == 3'd2) cnt2++;
    chk("lat4_wait_len", 32'(cnt2), 32'd6);
    chk("lat4_no_early_load", 32'(tr1[7].ld), 32'd0);
    chk("lat4_load_after_ready", 32'(tr1[8].ld), 32'd1);
    chk("lat1_load_after_ready", 32'(tr0[8].ld), 32'd1);

    // Stall freezes a jump retirement.
    do_reset();
    start = 1; imem_ready = 1;
    tick(); start = 0;
    wait_state0(3'd4, 20);
    tr0.delete(); tr1.delete();
    exec_done = 1; jump = 1; stall = 1;
    repeat (3) tick();
    stall = 0;
    tick();
    exec_done = 0; jump = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_state[%0d]", i), 32'(tr0[i].st), 32'd4);
      chk($sformatf("stall_strobes[%0d]", i), 32'({tr0[i].rd, tr0[i].ld, tr0[i].inc, tr0[i].wr}), 32'd0);
    end
    chk("jump_pc_write", 32'(tr0[3].wr), 32'd1);
    chk("jump_pc_inc", 32'(tr0[3].inc), 32'd0);

    // Halt at retirement, then resume.
    wait_state0(3'd4, 20);
    exec_done = 1; halt_req = 1;
    tick();
    exec_done = 0; halt_req = 0;
    chk("halt_state", 32'(b0.state), 32'd5);
    chk("halt_halted", 32'(b0.halted), 32'd1);
    chk("halt_busy", 32'(b0.busy), 32'd0);
`ifdef PC_SEQ_INSTR_CNT_EN
    chk("halt_cnt", 32'(b0.instr_cnt), 32'd2);
`endif
    repeat (2) tick();
    chk("halt_holds", 32'(b0.state), 32'd5);
    start = 1;
    tick(); start = 0;
    chk("resume_fetch", 32'(b0.state), 32'd1);
    wait_state0(3'd4, 20);
    exec_done = 1;
    tick(); exec_done = 0;
`ifdef PC_SEQ_INSTR_CNT_EN
    chk("resume_cnt", 32'(b0.instr_cnt), 32'd3);
`endif

    // Asynchronous reset during imem_rd, WAIT and pc_inc cycles.
    do_reset();
    start = 1;
    tick(); start = 0;
    chk("pre_rst_imem_rd", 32'(b0.imem_rd), 32'd1);
    #1 rst_n = 0;
    #1;
    chk("rst_drops_imem_rd", 32'(b0.imem_rd), 32'd0);
    chk("rst_fetch_state", 32'(b0.state), 32'd0);
    tick(); rst_n = 1;
    tick();
    start = 1;
    tick(); start = 0;
    wait_state0(3'd2, 10);
    rst_n = 0;
    #1;
    chk("rst_wait_state", 32'(b0.state), 32'd0);
    chk("rst_wait_busy", 32'(b0.busy), 32'd0);
    tick(); rst_n = 1;
    tick();
    start = 1; imem_ready = 1;
    tick(); start = 0;
    wait_state0(3'd4, 20);
    exec_done = 1;
    tick(); exec_done = 0;
    wait_state0(3'd4, 20);
    exec_done = 1; jump = 0;
    #1;
    chk("pre_rst_pc_inc", 32'(b0.pc_inc), 32'd1);
    #1 rst_n = 0;
    #1;
    chk("rst_drops_pc_inc", 32'(b0.pc_inc), 32'd0);
    chk("rst_exec_state", 32'(b0.state), 32'd0);
`ifdef PC_SEQ_INSTR_CNT_EN
    chk("rst_clears_cnt", 32'(b0.instr_cnt), 32'd0);
`endif
    exec_done = 0;
    tick(); rst_n = 1;
    repeat (6) tick();
    chk("post_rst_idle0", 32'(b0.state), 32'd0);
    chk("post_rst_idle1", 32'(b1.state), 32'd0);

    // 17 retirements on the 4-bit counter.
    do_reset();
    base = ret0_total;
    start = 1; imem_ready = 1; exec_done = 1;
    tick(); start = 0;
    n = 0;
    while ((ret0_total - base) < 17 && n < 200) begin
      jump = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    exec_done = 0; jump = 0;
    chk("wrap_retire_count", 32'(ret0_total - base), 32'd17);
`ifdef PC_SEQ_INSTR_CNT_EN
    chk("wrap_cnt", 32'(b0.instr_cnt), 32'd1);
`endif

    // Randomized traffic, including occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 3) == 0);
      halt_req   = ($urandom_range(0, 4) == 0);
      imem_ready = 1'($urandom_range(0, 1));
      exec_done  = ($urandom_range(0, 2) == 0);
      jump       = 1'($urandom_range(0, 1));
      stall      = ($urandom_range(0, 3) == 0);
      rst_n      = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
